// File: rtl/nand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_pkg                                                  |
// | Purpose  : Opcodes, FSM states and default timing for the NAND bus   |
// |            cycle engine.                                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package nand_pkg;

    typedef enum logic [7:0] {
        OP_CMD      = 8'h01,
        OP_ADDR     = 8'h02,
        OP_WDATA    = 8'h03,
        OP_RDATA    = 8'h04,
        OP_WAIT_RNB = 8'h05,
        OP_CE_ON    = 8'h06,
        OP_CE_OFF   = 8'h07,
        OP_WP       = 8'h08
    } nand_op_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SETUP    = 4'd1,
        ST_WE_LOW   = 4'd2,
        ST_WE_HIGH  = 4'd3,
        ST_RE_LOW   = 4'd4,
        ST_RE_HIGH  = 4'd5,
        ST_WB_WAIT  = 4'd6,
        ST_RNB_WAIT = 4'd7,
        ST_SINGLE   = 4'd8
    } nand_state_e;

    localparam int DEF_TWP  = 2;
    localparam int DEF_TWH  = 2;
    localparam int DEF_TWB  = 4;
    localparam int DEF_TOUT = 65535;

    function automatic logic op_is_valid(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h08);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_bus_cycle_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_bus_cycle_if                                         |
// | Purpose  : Host-side request/status bundle of the NAND bus engine.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface nand_bus_cycle_if;
    logic       activate;
    logic [7:0] cmd_in;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       timeout;

    modport master (
        output activate, cmd_in, data_in,
        input  data_out, busy, timeout
    );

    modport slave (
        input  activate, cmd_in, data_in,
        output data_out, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/nand_rnb_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_rnb_sync                                             |
// | Purpose  : Two-flop synchroniser for the asynchronous NAND R/nB pin. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module nand_rnb_sync (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic async_i,
    output logic      sync_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/nand_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_bus_cycle                                            |
// | Purpose  : Sequences single NAND flash bus cycles (command, address, |
// |            data write/read, ready wait, CE and WP control).          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module nand_bus_cycle
    import nand_pkg::*;
#(
    parameter int TWP  = DEF_TWP,
    parameter int TWH  = DEF_TWH,
    parameter int TWB  = DEF_TWB,
    parameter int TOUT = DEF_TOUT
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    nand_bus_cycle_if.slave  host,
    output logic             nand_cle,
    output logic             nand_ale,
    output logic             nand_nwe,
    output logic             nand_nre,
    output logic             nand_nce,
    output logic             nand_nwp,
    input  wire logic        nand_rnb,
    inout  wire [15:0]       nand_data
);
    nand_state_e state_q, state_d;
    nand_op_e    opc_q, opc_d;
    logic [7:0]  byte_q, byte_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic        cle_q, cle_d;
    logic        ale_q, ale_d;
    logic        nwe_q, nwe_d;
    logic        nre_q, nre_d;
    logic        nce_q, nce_d;
    logic        nwp_q, nwp_d;
    logic        oe_q, oe_d;
    logic        rnb_s;
    logic        w_wr_op;
    logic        w_wr_phase;

    nand_rnb_sync u_rnb_sync (
        .clk     (clk),
        .resetn  (resetn),
        .async_i (nand_rnb),
        .sync_o  (rnb_s)
    );

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        dout_d     = dout_q;
        timeout_d  = timeout_q;
        nce_d      = nce_q;
        nwp_d      = nwp_q;

        case (state_q)
            ST_IDLE: begin
                if (host.activate && op_is_valid(host.cmd_in)) begin
                    opc_d  = nand_op_e'(host.cmd_in);
                    byte_d = host.data_in;
                    case (opc_d)
                        OP_CMD, OP_ADDR, OP_WDATA, OP_RDATA: state_d = ST_SETUP;
                        OP_WAIT_RNB: begin
                            state_d   = ST_WB_WAIT;
                            cnt_d     = 4'(TWB - 1);
                            timeout_d = 1'b0;
                        end
                        default: state_d = ST_SINGLE;
                    endcase
                end
            end
            ST_SETUP: begin
                cnt_d   = 4'(TWP - 1);
                state_d = (opc_q == OP_RDATA) ? ST_RE_LOW : ST_WE_LOW;
            end
            ST_WE_LOW, ST_RE_LOW: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(TWH - 1);
                    state_d = (state_q == ST_RE_LOW) ? ST_RE_HIGH : ST_WE_HIGH;
                    if (state_q == ST_RE_LOW) begin
                        dout_d = nand_data[7:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WE_HIGH, ST_RE_HIGH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WB_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RNB_WAIT;
                    tcnt_d  = 16'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RNB_WAIT: begin
                if (rnb_s) begin
                    state_d = ST_IDLE;
                end else if (tcnt_q == 16'(TOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tcnt_q != 16'hFFFF) begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            ST_SINGLE: begin
                case (opc_q)
                    OP_CE_ON:  nce_d = 1'b0;
                    OP_CE_OFF: nce_d = 1'b1;
                    OP_WP:     nwp_d = byte_q[0];
                    default:   ;
                endcase
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin levels are registered from the next state so they switch on the same edge as the FSM.
        w_wr_op    = (opc_d == OP_CMD) || (opc_d == OP_ADDR) || (opc_d == OP_WDATA);
        w_wr_phase = w_wr_op && ((state_d == ST_SETUP) || (state_d == ST_WE_LOW) ||
                                 (state_d == ST_WE_HIGH));
        cle_d  = w_wr_phase && (opc_d == OP_CMD);
        ale_d  = w_wr_phase && (opc_d == OP_ADDR);
        oe_d   = w_wr_phase;
        nwe_d  = (state_d != ST_WE_LOW);
        nre_d  = (state_d != ST_RE_LOW);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            opc_q     <= OP_CMD;
            byte_q    <= 8'h00;
            cnt_q     <= 4'd0;
            tcnt_q    <= 16'd0;
            dout_q    <= 8'h00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cle_q     <= 1'b0;
            ale_q     <= 1'b0;
            nwe_q     <= 1'b1;
            nre_q     <= 1'b1;
            nce_q     <= 1'b1;
            nwp_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            byte_q    <= byte_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cle_q     <= cle_d;
            ale_q     <= ale_d;
            nwe_q     <= nwe_d;
            nre_q     <= nre_d;
            nce_q     <= nce_d;
            nwp_q     <= nwp_d;
            oe_q      <= oe_d;
        end
    end

    assign nand_data     = oe_q ? {8'h00, byte_q} : 16'hzzzz;
    assign nand_cle      = cle_q;
    assign nand_ale      = ale_q;
    assign nand_nwe      = nwe_q;
    assign nand_nre      = nre_q;
    assign nand_nce      = nce_q;
    assign nand_nwp      = nwp_q;
    assign host.data_out = dout_q;
    assign host.busy     = busy_q;
    assign host.timeout  = timeout_q;
endmodule
`default_nettype wire

// File: doc/nand_bus_cycle.md
NAND_BUS_CYCLE -- requirements
Module: nand_bus_cycle

Interface
REQ-001 Parameter TWP, default 2: nWE/nRE low width in clk cycles, legal range 1..15.
REQ-002 Parameter TWH, default 2: nWE/nRE high hold in clk cycles after the low phase, legal range 1..15.
REQ-003 Parameter TWB, default 4: minimum cycles before nand_rnb is examined in WAIT_RNB.
REQ-004 Parameter TOUT, default 65535: WAIT_RNB timeout in cycles.
REQ-005 Ports, with clk and resetn first; one clock; reset is asynchronous and active-low:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- activate  in  1  start-operation strobe.
- cmd_in  in  8  operation opcode.
- data_in  in  8  command/address/data byte to write.
- data_out  out  8  last byte read.
- busy  out  1  operation in progress.
- timeout  out  1  sticky flag: last WAIT_RNB expired.
- nand_cle, nand_ale, nand_nwe, nand_nre, nand_nce, nand_nwp  out  1  NAND control pins.
- nand_rnb  in  1  NAND ready/busy, asynchronous.
- nand_data  inout  16  NAND data bus.

Function
REQ-006 Opcodes SHALL be: 01 CMD, 02 ADDR, 03 WDATA, 04 RDATA, 05 WAIT_RNB, 06 CE_ON, 07 CE_OFF, 08 WP (nand_nwp <= data_in[0]).
REQ-007 activate SHALL be sampled only when busy=0; busy SHALL rise on the following edge; activate while busy=1 SHALL be ignored.
REQ-008 An unknown opcode SHALL be ignored; busy stays 0.
REQ-009 Opcode and data_in SHALL be latched at acceptance; later changes SHALL have no effect on the running operation.
REQ-010 The FSM SHALL have the states IDLE, SETUP, WE_LOW, WE_HIGH, RE_LOW, RE_HIGH, WB_WAIT, RNB_WAIT, SINGLE.
REQ-011 CMD/ADDR/WDATA SHALL run IDLE->SETUP(1)->WE_LOW(TWP)->WE_HIGH(TWH)->IDLE.
REQ-012 During CMD/ADDR/WDATA, CLE (CMD) or ALE (ADDR) SHALL be held high, and nand_data SHALL be driven {8'h00,byte}, from SETUP through the end of WE_HIGH.
REQ-013 During CMD/ADDR/WDATA, nWE SHALL be low in WE_LOW only.
REQ-014 RDATA SHALL run IDLE->SETUP(1)->RE_LOW(TWP)->RE_HIGH(TWH)->IDLE, with nand_data high-Z throughout.
REQ-015 In RDATA, data_out SHALL capture nand_data[7:0] on the edge ending RE_LOW.
REQ-016 For CMD/ADDR/WDATA/RDATA, busy SHALL be high for exactly 1+TWP+TWH cycles.
REQ-017 WAIT_RNB SHALL clear timeout at acceptance and then wait TWB cycles in WB_WAIT.
REQ-018 After WB_WAIT, WAIT_RNB SHALL remain in RNB_WAIT until the synchronised rnb=1 (then IDLE) or TOUT cycles elapse (set timeout=1, then IDLE).
REQ-019 CE_ON/CE_OFF/WP SHALL use SINGLE: busy high 1 cycle, with the pin updated on the SINGLE edge.
REQ-020 nand_nce SHALL change only via CE_ON/CE_OFF and SHALL never toggle implicitly.
REQ-021 nand_rnb SHALL pass through a 2-flop synchroniser before any use.
REQ-022 Phase counters SHALL be 4-bit; the timeout counter SHALL be 16-bit, saturating; no wrap SHALL cause a false completion.
REQ-023 An edge that ends an operation SHALL NOT also accept a new one; the earliest re-acceptance is the cycle after busy falls.

Reset
REQ-024 On resetn=0 all outputs SHALL go immediately: cle=0, ale=0, nwe=1, nre=1, nce=1, nwp=0, nand_data high-Z, data_out=0, busy=0, timeout=0, FSM=IDLE.
REQ-025 Reset mid-operation SHALL abort the operation with no completion side effects; the synchroniser SHALL clear to 0.

Structure
REQ-026 Package nand_pkg SHALL hold the opcode enum, state enum, and default timing constants.
REQ-027 Sub-module nand_rnb_sync (2-flop synchroniser, async active-low reset) SHALL be instantiated once.
REQ-028 The tristate SHALL be a single continuous assignment gated by an internal oe register.

Verification
REQ-029 CMD 8'h70, defaults -> CLE=1 and data=16'h0070 for 5 cycles, nWE low cycles 2-3, busy high 5 cycles.
REQ-030 RDATA with the bench driving 8'hA5 during nRE low -> data_out=8'hA5, nand_data never driven by DUT.
REQ-031 WAIT_RNB, rnb low 20 cycles then high -> busy falls 2-3 cycles after rnb rises, timeout=0; with TOUT=16 and rnb held low -> timeout=1, busy falls.
REQ-032 activate pulsed during a busy WDATA and on its final edge -> both ignored; next accept on a later pulse.
REQ-033 resetn low in WE_LOW of ADDR 8'h00 -> ale=0, nwe=1, bus high-Z same cycle, busy=0.
REQ-034 CE_ON, WP data_in=1, unknown opcode 8'hFF -> nce=0, nwp=1, busy 1 cycle each; the unknown opcode gives no busy.
